// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned 32x32 multiply / 32/32 divide sequencer.
// It owns no adder of its own; every iteration is routed through the shared
// ALU adder path (alu_in1/alu_in2/alu_binvert/alu_cin -> alu_out/alu_cout).
//
// Handshake: a command is accepted on a rising edge where the block is in
// IDLE and start is high; busy rises after that edge and stays high through
// the single DONE cycle, during which done pulses for exactly one cycle.
// start is ignored (not queued) while busy. result_lo/result_hi/div0 come
// from dedicated result registers, loaded on the last iteration edge, so
// they keep showing the previous result while a new command runs.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [1:0]  alu_op,
  output logic        alu_binvert,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic        mode;       // 0 = multiply, 1 = divide
  logic [31:0] mcand;      // multiplicand, or divisor in divide mode
  logic [31:0] hi;         // product high half / partial remainder
  logic [31:0] lo;         // multiplier shift reg / quotient shift reg
  logic        div0_q;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        res_div0;

  logic [32:0] s;          // divide: partial remainder shifted left by one
  logic        ge;         // divide: shifted remainder >= divisor
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic        last_iter;

  assign s         = {hi, lo[31]};
  assign ge        = s[32] | alu_cout;
  assign last_iter = (state == S_RUN) && (cnt == 5'd31);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and ALU drive; the ALU sits idle outside RUN
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    alu_in1     = 32'd0;
    alu_in2     = 32'd0;
    alu_op      = 2'b00;
    alu_binvert = 1'b0;
    alu_cin     = 1'b0;
    if (state == S_RUN) begin
      alu_op = 2'b10;
      if (mode) begin
        // trial subtraction: s[31:0] - divisor as s + ~divisor + 1
        alu_in1     = s[31:0];
        alu_in2     = mcand;
        alu_binvert = 1'b1;
        alu_cin     = 1'b1;
      end else begin
        alu_in1 = hi;
        alu_in2 = lo[0] ? mcand : 32'd0;
      end
    end
  end

  // One iteration's worth of register update, built from the ALU result
  always_comb begin
    step_hi = hi;
    step_lo = lo;
    if (mode) begin
      // restoring divide: keep the difference only when it did not underflow
      step_hi = ge ? alu_out : s[31:0];
      step_lo = {lo[30:0], ge};
    end else begin
      // shift-add multiply: carry-out becomes the new top bit of hi
      step_hi = {alu_cout, alu_out[31:1]};
      step_lo = {alu_out[0], lo[31:1]};
    end
  end

  // Working registers: load on accept, iterate during RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      mode   <= 1'b0;
      mcand  <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      div0_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= 5'd0;
            mode   <= op_div;
            mcand  <= op_div ? operand_b : operand_a;
            hi     <= 32'd0;
            lo     <= op_div ? operand_a : operand_b;
            div0_q <= op_div && (operand_b == 32'd0);
          end
        end
        S_RUN: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= (cnt == 5'd31) ? 5'd0 : cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: captured on the RUN->DONE edge, held until the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_lo   <= 32'd0;
      res_hi   <= 32'd0;
      res_div0 <= 1'b0;
    end else if (last_iter) begin
      res_lo   <= step_lo;
      res_hi   <= step_hi;
      res_div0 <= div0_q;
    end
  end

  assign result_lo = res_lo;
  assign result_hi = res_hi;
  assign div0      = res_div0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: models the shared ALU adder, issues directed
// MUL/DIV commands with hand-computed results, and checks results through a
// scoreboard queue popped by a monitor on every done pulse.
module tb_muldiv_seq;

  localparam int W = 65;  // {div0, result_hi, result_lo}

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [1:0]  alu_op;
  logic        alu_binvert;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic        alu_cout;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_div      (op_div),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .div0        (div0),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_op      (alu_op),
    .alu_binvert (alu_binvert),
    .alu_cin     (alu_cin),
    .alu_out     (alu_out),
    .alu_cout    (alu_cout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model (add path only) ----------------
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = 33'd0;
    if (alu_op == 2'b10)
      alu_sum = {1'b0, alu_in1} + {1'b0, (alu_binvert ? ~alu_in2 : alu_in2)} + {32'd0, alu_cin};
  end
  assign alu_out  = alu_sum[31:0];
  assign alu_cout = alu_sum[32];

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with empty queue, expected no done");
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("result_lo", {32'd0, result_lo}, {32'd0, e[31:0]});
        chk("result_hi", {32'd0, result_hi}, {32'd0, e[63:32]});
        chk("div0",      {63'd0, div0},      {63'd0, e[64]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the block idle; returns at a negedge after done.
  task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic ediv0);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    op_div    = d;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    exp_q.push_back({ediv0, ehi, elo});
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("alu_op_run",  {62'd0, alu_op},      64'd2);
        chk("alu_binv",    {63'd0, alu_binvert}, {63'd0, d});
        chk("alu_cin",     {63'd0, alu_cin},     {63'd0, d});
        chk("alu_in1_it1", {32'd0, alu_in1},     d ? {63'd0, a[31]} : 64'd0);
        chk("alu_in2_it1", {32'd0, alu_in2},     d ? {32'd0, b} : (b[0] ? {32'd0, a} : 64'd0));
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_at = cyc;
        break;
      end
    end
    chk("done_latency", done_at, 33);
    chk("busy_cycles",  busy_cnt, 33);
    @(negedge clk);
    chk("idle_busy",   {63'd0, busy}, 64'd0);
    chk("idle_done",   {63'd0, done}, 64'd0);
    chk("hold_lo",     {32'd0, result_lo}, {32'd0, elo});
    chk("hold_hi",     {32'd0, result_hi}, {32'd0, ehi});
    chk("idle_alu_op", {62'd0, alu_op}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_cnt;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op_div    = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_div0",  {63'd0, div0}, 64'd0);
    chk("rst_lo",    {32'd0, result_lo}, 64'd0);
    chk("rst_hi",    {32'd0, result_hi}, 64'd0);
    chk("rst_alu",   {alu_in1, alu_in2}, 64'd0);
    chk("rst_aluop", {60'd0, alu_op, alu_binvert, alu_cin}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'd7,          32'd6,          32'd42,         32'd0,          1'b0);
    issue(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE,   1'b0);
    issue(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    issue(1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0);
    issue(1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1);

    // start pulsed mid-run must be ignored
    op_div    = 1'b0;
    operand_a = 32'd3;
    operand_b = 32'd5;
    start     = 1'b1;
    exp_q.push_back({1'b0, 32'd0, 32'd15});
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);  // E4
    #1;
    op_div    = 1'b1;
    operand_a = 32'd77;
    operand_b = 32'd9;
    start     = 1'b1;
    @(posedge clk);  // E5
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("run_hold_lo", {32'd0, result_lo}, 64'hFFFFFFFF);
    chk("run_hold_hi", {32'd0, result_hi}, 64'h12345678);
    chk("run_hold_d0", {63'd0, div0}, 64'd1);
    done_cnt = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("single_done", done_cnt, 1);
    chk("mid_busy_end", {63'd0, busy}, 64'd0);

    // reset in the middle of a divide aborts it
    op_div    = 1'b1;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start     = 1'b1;
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);  // E9
    #1;
    rst_n = 1'b0;
    @(posedge clk);  // E10
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_lo",   {32'd0, result_lo}, 64'd0);
    chk("abort_hi",   {32'd0, result_hi}, 64'd0);
    chk("abort_div0", {63'd0, div0}, 64'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    issue(1'b1, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0);

    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
